banco_entrada: RTL and testbench



---
 rtl/banco_entrada_if.sv | 44 ++++
 rtl/banco_entrada.sv | 108 ++++++++++
 tb/tb_banco_entrada.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/banco_entrada_if.sv
`default_nettype none
// ============================================================================
//  Module      : banco_entrada_if
//  Description : Port bundle for the input-port bank. The device side carries
//                four data bytes and their strobes. The CPU side carries the
//                port select, the read-consume strobe, the selected byte and
//                the per-port status and acknowledge flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface banco_entrada_if #(
    parameter int WIDTH = 8
);

    // Device side: data bytes and asynchronous strobes
    logic [WIDTH-1:0] din0;
    logic [WIDTH-1:0] din1;
    logic [WIDTH-1:0] din2;
    logic [WIDTH-1:0] din3;
    logic [3:0]       stb;

    // CPU side: select and consume
    logic [1:0]       sel;
    logic             re;

    // Bank outputs
    logic [WIDTH-1:0] rd;
    logic [3:0]       valid;
    logic [3:0]       overrun;
    logic [3:0]       ack;

    // Driver of stimulus (devices + CPU)
    modport master (
        output din0, din1, din2, din3, stb, sel, re,
        input  rd, valid, overrun, ack
    );

    // The bank itself
    modport slave (
        input  din0, din1, din2, din3, stb, sel, re,
        output rd, valid, overrun, ack
    );

endinterface
`default_nettype wire

// File: rtl/banco_entrada.sv
`default_nettype none
// ============================================================================
//  Module      : banco_entrada
//  Description : Four-port input bank for the 8-bit CPU. Each port
//                synchronizes its strobe and latches the device byte on the
//                strobe rising edge. The byte is held with a valid flag until
//                the CPU consumes it. A consume clears the flags and returns a
//                one-cycle acknowledge to the device. A sticky overrun flag
//                marks a held byte that was replaced before it was read.
//  Revision    : 1.0 - initial release
// ============================================================================
module banco_entrada #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic           clk,
    input  wire logic           reset,
    banco_entrada_if.slave      bus
);

    localparam int c_NUM_PORTS = 4;

    // Device bytes gathered into an array so the ports can be generated
    logic [WIDTH-1:0]       w_din  [c_NUM_PORTS];
    // Hold register contents, exported from each port for the read mux
    logic [WIDTH-1:0]       w_hold [c_NUM_PORTS];
    logic [c_NUM_PORTS-1:0] w_valid;
    logic [c_NUM_PORTS-1:0] w_overrun;
    logic [c_NUM_PORTS-1:0] w_ack;

    assign w_din[0] = bus.din0;
    assign w_din[1] = bus.din1;
    assign w_din[2] = bus.din2;
    assign w_din[3] = bus.din3;

    generate
        for (genvar i = 0; i < c_NUM_PORTS; i++) begin : g_port
            logic [SYNC_STAGES-1:0] r_sync;
            logic                   r_prev;
            logic                   w_rise;
            logic                   w_consume;
            logic [WIDTH-1:0]       r_hold;
            logic                   r_valid;
            logic                   r_overrun;
            logic                   r_ack;

            // Strobe synchronizer chain plus one flop for edge detection
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync <= '0;
                    r_prev <= 1'b0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], bus.stb[i]};
                    r_prev <= r_sync[SYNC_STAGES-1];
                end
            end

            // One-cycle pulse per strobe rise, independent of strobe width.
            // Since prev clears on reset, a strobe still high at release
            // counts as a fresh rise.
            assign w_rise    = r_sync[SYNC_STAGES-1] & ~r_prev;
            assign w_consume = bus.re && (bus.sel == 2'(i));

            // Hold register, status flags and acknowledge for this port.
            // When a capture and a consume land on the same edge, the consume
            // counts against the byte already held. The new byte then stays
            // valid and no overrun is recorded.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_hold    <= '0;
                    r_valid   <= 1'b0;
                    r_overrun <= 1'b0;
                    r_ack     <= 1'b0;
                end else begin
                    r_ack <= w_consume;
                    if (w_rise) begin
                        r_hold  <= w_din[i];
                        r_valid <= 1'b1;
                        if (w_consume) begin
                            r_overrun <= 1'b0;
                        end else if (r_valid) begin
                            r_overrun <= 1'b1;
                        end
                    end else if (w_consume) begin
                        r_valid   <= 1'b0;
                        r_overrun <= 1'b0;
                    end
                end
            end

            assign w_hold[i]    = r_hold;
            assign w_valid[i]   = r_valid;
            assign w_overrun[i] = r_overrun;
            assign w_ack[i]     = r_ack;
        end
    endgenerate

    // CPU read path: selected hold register, no register stage in between
    always_comb begin
        bus.rd = w_hold[bus.sel];
    end

    assign bus.valid   = w_valid;
    assign bus.overrun = w_overrun;
    assign bus.ack     = w_ack;

endmodule
`default_nettype wire

// File: tb/tb_banco_entrada.sv
`default_nettype none
// ============================================================================
//  Module      : tb_banco_entrada
//  Description : Self-checking bench for banco_entrada. A small behavioural
//                model tracks the held bytes and flags of each port. Every
//                read pushes its expected byte and acknowledge into a
//                scoreboard, and the entry is popped and compared when the
//                acknowledge appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_banco_entrada;

    logic clk;
    logic reset;

    banco_entrada_if #(.WIDTH(8)) bus ();

    banco_entrada #(
        .WIDTH       (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] ack;
        logic [7:0] rd;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] exp_hold [4];
    logic [3:0] exp_valid;
    logic [3:0] exp_ovr;
    int         checks;
    int         errors;

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) exp_hold[i] = 8'h00;
        exp_valid = 4'h0;
        exp_ovr   = 4'h0;
    endtask

    task automatic set_din(input int p, input logic [7:0] d);
        case (p)
            0: bus.din0 = d;
            1: bus.din1 = d;
            2: bus.din2 = d;
            default: bus.din3 = d;
        endcase
    endtask

    // Raise the strobes in mask for one cycle. Verify that nothing is
    // captured one edge early and that capture occurs on edge k+2.
    task automatic strobe(input logic [3:0] mask, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
        logic [7:0] dv [4];
        dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
        for (int i = 0; i < 4; i++) if (mask[i]) set_din(i, dv[i]);
        bus.stb = bus.stb | mask;
        tick();                       // edge k: strobe first sampled
        bus.stb = bus.stb & ~mask;
        tick();                       // edge k+1
        checks++;
        if (bus.valid !== exp_valid) begin
            errors++;
            $display("FAIL strobe_early_valid: got %b expected %b", bus.valid, exp_valid);
        end
        tick();                       // edge k+2: capture
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                if (exp_valid[i]) exp_ovr[i] = 1'b1;
                exp_hold[i]  = dv[i];
                exp_valid[i] = 1'b1;
            end
        end
        checks++;
        if (bus.valid !== exp_valid) begin
            errors++;
            $display("FAIL strobe_valid: got %b expected %b", bus.valid, exp_valid);
        end
        checks++;
        if (bus.overrun !== exp_ovr) begin
            errors++;
            $display("FAIL strobe_overrun: got %b expected %b", bus.overrun, exp_ovr);
        end
        repeat (3) tick();
    endtask

    // One CPU read of port p, followed by an idle cycle
    task automatic do_read(input int p);
        exp_t e;
        bus.sel = 2'(p);
        bus.re  = 1'b1;
        #1;
        checks++;
        if (bus.rd !== exp_hold[p]) begin
            errors++;
            $display("FAIL read_rd_pre p%0d: got %h expected %h", p, bus.rd, exp_hold[p]);
        end
        sb.push_back('{ack: 4'(1 << p), rd: exp_hold[p]});
        exp_valid[p] = 1'b0;
        exp_ovr[p]   = 1'b0;
        tick();
        bus.re = 1'b0;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL read_scoreboard: queue empty");
        end else begin
            e = sb.pop_front();
            checks++;
            if (bus.ack !== e.ack) begin
                errors++;
                $display("FAIL read_ack p%0d: got %b expected %b", p, bus.ack, e.ack);
            end
            checks++;
            if (bus.rd !== e.rd) begin
                errors++;
                $display("FAIL read_rd_post p%0d: got %h expected %h", p, bus.rd, e.rd);
            end
        end
        checks++;
        if (bus.valid !== exp_valid || bus.overrun !== exp_ovr) begin
            errors++;
            $display("FAIL read_flags p%0d: got v=%b o=%b expected v=%b o=%b",
                     p, bus.valid, bus.overrun, exp_valid, exp_ovr);
        end
        tick();
        checks++;
        if (bus.ack !== 4'h0) begin
            errors++;
            $display("FAIL read_ack_drop p%0d: got %b expected 0000", p, bus.ack);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        bus.din0 = 8'hA5;
        bus.stb  = 4'b0001;
        model_reset();
        repeat (3) tick();
        checks++;
        if (bus.rd !== 8'h00 || bus.valid !== 4'h0 || bus.overrun !== 4'h0 || bus.ack !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%h v=%b o=%b a=%b expected all zero",
                     bus.rd, bus.valid, bus.overrun, bus.ack);
        end
        reset = 1'b0;
        tick();                       // first edge with reset low samples stb
        tick();
        checks++;
        if (bus.valid !== 4'h0) begin
            errors++;
            $display("FAIL reset_release_early: got %b expected 0000", bus.valid);
        end
        tick();
        exp_hold[0]  = 8'hA5;
        exp_valid[0] = 1'b1;
        checks++;
        if (bus.valid !== 4'b0001 || bus.rd !== 8'hA5) begin
            errors++;
            $display("FAIL reset_release_capture: got v=%b rd=%h expected v=0001 rd=a5",
                     bus.valid, bus.rd);
        end
        bus.stb = 4'b0000;
        repeat (3) tick();
        do_read(0);
    endtask

    task automatic test_single_transfer();
        strobe(4'b0100, 8'h00, 8'h00, 8'h3C, 8'h00);
        do_read(2);
    endtask

    task automatic test_stale_read();
        // port 2 already consumed: stale byte, ack still pulses
        do_read(2);
    endtask

    task automatic test_overrun();
        strobe(4'b0010, 8'h00, 8'h11, 8'h00, 8'h00);
        strobe(4'b0010, 8'h00, 8'h22, 8'h00, 8'h00);
        bus.sel = 2'd1;
        #1;
        checks++;
        if (bus.rd !== 8'h22 || bus.overrun[1] !== 1'b1 || bus.valid[1] !== 1'b1) begin
            errors++;
            $display("FAIL overrun_state: got rd=%h o=%b v=%b expected rd=22 o[1]=1 v[1]=1",
                     bus.rd, bus.overrun, bus.valid);
        end
        do_read(1);
    endtask

    task automatic test_simultaneous();
        exp_t e;
        strobe(4'b1000, 8'h00, 8'h00, 8'h00, 8'h01);
        bus.din3 = 8'h02;
        bus.stb  = 4'b1000;
        tick();                       // edge k
        bus.stb  = 4'b0000;
        tick();                       // edge k+1
        bus.sel  = 2'd3;
        bus.re   = 1'b1;
        #1;
        checks++;
        if (bus.rd !== 8'h01) begin
            errors++;
            $display("FAIL simul_rd_pre: got %h expected 01", bus.rd);
        end
        sb.push_back('{ack: 4'b1000, rd: 8'h02});
        exp_hold[3] = 8'h02;
        exp_valid[3] = 1'b1;
        exp_ovr[3]   = 1'b0;
        tick();                       // edge k+2: capture and consume together
        bus.re = 1'b0;
        e = sb.pop_front();
        checks++;
        if (bus.ack !== e.ack || bus.rd !== e.rd) begin
            errors++;
            $display("FAIL simul_ack_rd: got ack=%b rd=%h expected ack=%b rd=%h",
                     bus.ack, bus.rd, e.ack, e.rd);
        end
        checks++;
        if (bus.valid !== exp_valid || bus.overrun !== exp_ovr) begin
            errors++;
            $display("FAIL simul_flags: got v=%b o=%b expected v=%b o=%b",
                     bus.valid, bus.overrun, exp_valid, exp_ovr);
        end
        repeat (3) tick();
        do_read(3);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        strobe(4'b1111, 8'h10, 8'h11, 8'h12, 8'h13);
        for (int p = 0; p < 4; p++) begin
            bus.sel = 2'(p);
            bus.re  = 1'b1;
            #1;
            checks++;
            if (bus.rd !== exp_hold[p]) begin
                errors++;
                $display("FAIL b2b_rd p%0d: got %h expected %h", p, bus.rd, exp_hold[p]);
            end
            sb.push_back('{ack: 4'(1 << p), rd: exp_hold[p]});
            exp_valid[p] = 1'b0;
            tick();
            e = sb.pop_front();
            checks++;
            if (bus.ack !== e.ack) begin
                errors++;
                $display("FAIL b2b_ack p%0d: got %b expected %b", p, bus.ack, e.ack);
            end
        end
        bus.re = 1'b0;
        tick();
        checks++;
        if (bus.ack !== 4'h0 || bus.valid !== 4'h0) begin
            errors++;
            $display("FAIL b2b_final: got ack=%b v=%b expected 0000 0000", bus.ack, bus.valid);
        end
    endtask

    task automatic test_reset_in_flight();
        bus.din0 = 8'h77;
        bus.stb  = 4'b0001;
        tick();                       // strobe enters synchronizer
        bus.stb  = 4'b0000;
        reset    = 1'b1;
        repeat (2) tick();
        reset    = 1'b0;
        model_reset();
        repeat (5) tick();
        bus.sel = 2'd0;
        #1;
        checks++;
        if (bus.valid !== 4'h0 || bus.rd !== 8'h00 || bus.overrun !== 4'h0) begin
            errors++;
            $display("FAIL inflight_discard: got v=%b rd=%h o=%b expected 0000 00 0000",
                     bus.valid, bus.rd, bus.overrun);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        bus.din0 = 8'h00;
        bus.din1 = 8'h00;
        bus.din2 = 8'h00;
        bus.din3 = 8'h00;
        bus.stb  = 4'h0;
        bus.sel  = 2'd0;
        bus.re   = 1'b0;
        test_reset();
        test_single_transfer();
        test_stale_read();
        test_overrun();
        test_simultaneous();
        test_back_to_back();
        test_reset_in_flight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
